// File: rtl/thirty_two_bit_divider.sv
// ============================================================================
// Module   : thirty_two_bit_divider
// Purpose  : Restoring divider that produces one quotient bit per cycle.
//            Define DIVIDER_SIGNED_EN to enable truncating signed division.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thirty_two_bit_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;
  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_step = c_cnt_w'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_dividend;
  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_part_rem;
  logic [WIDTH-1:0]   r_part_quo;
  logic               r_zero;
  logic               w_accept;
  logic [WIDTH-1:0]   w_op1;
  logic [WIDTH-1:0]   w_op2;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_quo_final;
  logic [WIDTH-1:0]   w_rem_final;
  logic [1:0]         w_unused_bits;

  assign w_accept = start && ((r_state == c_idle) || (r_state == c_done));

  always_ff @(posedge clk) begin
    if (reset) r_state <= c_idle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (start) w_state_next = c_busy;
      c_busy:  if (r_count == c_last_step) w_state_next = c_done;
      c_done:  w_state_next = start ? c_busy : c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  always_comb begin
    busy = (r_state == c_busy);
    done = (r_state == c_done);
  end

  // One restoring step: the extra top bit of w_diff is the borrow/sign.
  assign w_shift       = {r_part_rem, r_dividend[WIDTH-1]};
  assign w_diff        = {1'b0, w_shift} - {2'b00, r_divisor};
  assign w_fits        = ~w_diff[WIDTH+1];
  assign w_rem_step    = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_step    = {r_part_quo[WIDTH-2:0], w_fits};
  assign w_unused_bits = {w_diff[WIDTH], r_part_quo[WIDTH-1]};

`ifdef DIVIDER_SIGNED_EN
  logic w_neg1;
  logic w_neg2;
  logic r_neg_quo;
  logic r_neg_rem;

  assign w_neg1 = is_signed & in1[WIDTH-1];
  assign w_neg2 = is_signed & in2[WIDTH-1];
  assign w_op1  = w_neg1 ? -in1 : in1;
  assign w_op2  = w_neg2 ? -in2 : in2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_quo <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_neg_quo <= w_neg1 ^ w_neg2;
      r_neg_rem <= w_neg1;
    end
  end

  // A zero divisor still leaves |in1| as remainder, so re-signing restores in1.
  assign w_quo_final = r_zero ? '1 : (r_neg_quo ? -w_quo_step : w_quo_step);
  assign w_rem_final = r_neg_rem ? -w_rem_step : w_rem_step;
`else
  logic w_unused_is_signed;

  assign w_unused_is_signed = is_signed;
  assign w_op1       = in1;
  assign w_op2       = in2;
  assign w_quo_final = w_quo_step;
  assign w_rem_final = w_rem_step;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_part_rem  <= '0;
      r_part_quo  <= '0;
      r_zero      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_count    <= '0;
      r_dividend <= w_op1;
      r_divisor  <= w_op2;
      r_part_rem <= '0;
      r_part_quo <= '0;
      r_zero     <= (in2 == '0);
    end else if (r_state == c_busy) begin
      r_count    <= r_count + 1'b1;
      r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
      r_part_rem <= w_rem_step;
      r_part_quo <= w_quo_step;
      if (r_count == c_last_step) begin
        quotient    <= w_quo_final;
        remainder   <= w_rem_final;
        div_by_zero <= r_zero;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_thirty_two_bit_divider.sv
// Self-checking bench for thirty_two_bit_divider: directed cases plus
// randomized traffic compared every cycle against an arithmetic model.
`default_nettype none

module tb_thirty_two_bit_divider;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;
  bit checking = 1'b0;
  bit saw_done = 1'b0;

  thirty_two_bit_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .in1(in1), .in2(in2), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for one division.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF; r = a; dz = 1'b1;
    end else begin
      dz = 1'b0;
`ifdef DIVIDER_SIGNED_EN
      if (s) begin
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b; r = a % b;
      end
`else
      q = a / b; r = a % b;
`endif
    end
  endtask

  // Cycle-level model: phase 0 idle, 1..32 iterating, 33 results valid.
  int          m_phase = 0;
  logic [31:0] m_a = '0, m_b = '0, m_q = '0, m_r = '0;
  logic        m_s = 1'b0, m_dz = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_q = '0; m_r = '0; m_dz = 1'b0;
    end else if (start && (m_phase == 0 || m_phase == 33)) begin
      m_phase = 1; m_a = in1; m_b = in2; m_s = is_signed;
    end else if (m_phase >= 1 && m_phase <= 32) begin
      m_phase++;
      if (m_phase == 33) ref_div(m_a, m_b, m_s, m_q, m_r, m_dz);
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      logic exp_busy;
      logic exp_done;
      exp_busy = (m_phase >= 1 && m_phase <= 32);
      exp_done = (m_phase == 33);
      if (done) begin n_done++; saw_done = 1'b1; end
      n_tests++;
      if (busy !== exp_busy || done !== exp_done || quotient !== m_q ||
          remainder !== m_r || div_by_zero !== m_dz) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t busy=%b/%b done=%b/%b q=%h/%h r=%h/%h dz=%b/%b (got/expected)",
                 $time, busy, exp_busy, done, exp_done, quotient, m_q, remainder, m_r,
                 div_by_zero, m_dz);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(posedge clk); #1;
    start = 1'b1; in1 = a; in2 = b; is_signed = s;
    @(posedge clk); #1;
    start = 1'b0; in1 = $urandom; in2 = $urandom; is_signed = 1'($urandom);
  endtask

  // Called #1 after the accept edge; returns cycles until done (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic divide(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] eq, input logic [31:0] er,
                        input logic edz);
    int lat;
    launch(a, b, s);
    wait_done(lat);
    check({name, "_latency"}, lat, 33);
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dz"}, edz, div_by_zero);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    @(posedge clk); #1;
    checking = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_q", quotient, 0);
    check("reset_r", remainder, 0);
    check("reset_dz", div_by_zero, 0);

    divide("div_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
    divide("div_by_zero", 32'hDEADBEEF, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1);
    divide("div_clears_dz", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);

    // Start held through BUSY with other operands, then re-accepted in DONE.
    @(posedge clk); #1;
    start = 1'b1; in1 = 32'd1000; in2 = 32'd10; is_signed = 1'b0;
    @(posedge clk); #1;
    in1 = 32'd5; in2 = 32'd5;
    wait_done(lat);
    check("held_start_latency", lat, 33);
    check("held_start_q", quotient, 32'd100);
    check("held_start_r", remainder, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("restart_in_done_busy", busy, 1);
    wait_done(lat);
    check("restart_latency", lat, 32);
    check("restart_q", quotient, 32'd1);
    check("restart_r", remainder, 32'd0);

    // Reset part-way through an operation.
    launch(32'd123456, 32'd789, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", div_by_zero, 0);
    saw_done = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", saw_done, 0);
    divide("div_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);

`ifdef DIVIDER_SIGNED_EN
    divide("sdiv_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    divide("sdiv_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
    divide("sdiv_zero", 32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
`else
    divide("signed_ignored", 32'hFFFFFFF9, 32'd2, 1'b1, 32'h7FFFFFFC, 32'd1, 1'b0);
`endif

    // Randomized traffic: starts in every state, occasional resets.
    n_done = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #1;
      reset     = ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 3) == 0);
      is_signed = 1'($urandom);
      in1       = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       in2 = 32'd0;
        1:       in2 = 32'hFFFFFFFF;
        2:       in2 = 32'($urandom_range(1, 15));
        3:       in2 = -32'($urandom_range(1, 15));
        default: in2 = $urandom;
      endcase
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    repeat (40) @(posedge clk);
    check("random_done_count_ok", (n_done >= 80) ? 32'd1 : 32'd0, 32'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/thirty_two_bit_divider.md
THIRTY_TWO_BIT_DIVIDER -- requirements
Module: thirty_two_bit_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division.
REQ-005 SHALL have port is_signed  input  1  selects signed division; see REQ-025.
REQ-006 SHALL have port in1  input  32  dividend.
REQ-007 SHALL have port in2  input  32  divisor.
REQ-008 SHALL have port busy  output  1  high while iterating.
REQ-009 SHALL have port done  output  1  one-cycle pulse when results become valid.
REQ-010 SHALL have port quotient  output  32  result quotient.
REQ-011 SHALL have port remainder  output  32  result remainder.
REQ-012 SHALL have port div_by_zero  output  1  high with results when in2 was 0.

Function
REQ-013 SHALL implement states IDLE, BUSY, DONE; IDLE->BUSY on accepted start; BUSY->DONE after 32 iterations; DONE->IDLE after one cycle, or DONE->BUSY if start is high in DONE.
REQ-014 SHALL accept start only in IDLE or DONE, latching in1, in2 and is_signed on that edge.
REQ-015 SHALL ignore start while in BUSY; the latched operands are not disturbed.
REQ-016 SHALL, with start accepted at edge N, hold busy high for cycles N+1..N+32 and drive done high for exactly cycle N+33.
REQ-017 SHALL perform one restoring step per BUSY cycle: shift partial remainder left, insert next dividend bit (MSB first), subtract divisor with a 33-bit difference, keep the result and set the quotient bit if the difference is non-negative, else restore.
REQ-018 SHALL update quotient, remainder and div_by_zero only on entry to DONE, and hold them unchanged until the next entry to DONE.
REQ-019 SHALL, for in2 = 0, produce quotient = 32'hFFFFFFFF, remainder = in1, div_by_zero = 1, with latency unchanged.
REQ-020 SHALL clear div_by_zero on every DONE entry where in2 was non-zero.
REQ-021 SHALL compute unsigned results with quotient = floor(in1/in2) and remainder = in1 - quotient*in2.
REQ-022 SHALL keep busy and done mutually exclusive; done never asserts without a preceding accepted start.

Reset
REQ-023 SHALL, when reset is high at a rising edge, enter IDLE and drive busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0.
REQ-024 SHALL abort any operation in progress on reset, produce no done pulse for it, and give reset priority over a simultaneous start.

Configuration
REQ-025 SHALL honour macro DIVIDER_SIGNED_EN: when defined, is_signed = 1 divides magnitudes and then negates the quotient if the operand signs differ and gives the remainder the dividend's sign (truncating division); 32'h80000000 / 32'hFFFFFFFF yields quotient 32'h80000000, remainder 0; a zero divisor yields quotient 32'hFFFFFFFF, remainder = in1.
REQ-026 SHALL, when DIVIDER_SIGNED_EN is undefined, ignore is_signed and perform unsigned division only, with no sign-handling logic synthesized.
REQ-027 SHALL keep latency per REQ-016 identical in both configurations.

Verification
REQ-028 SHALL cover: start, in1 = 100, in2 = 7 -> done exactly 33 cycles after start, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-029 SHALL cover: in1 = 32'hDEADBEEF, in2 = 0 -> quotient = 32'hFFFFFFFF, remainder = 32'hDEADBEEF, div_by_zero = 1.
REQ-030 SHALL cover: start held high during BUSY with different operands -> results still reflect the first operands; a second start in the DONE cycle begins a new division, with busy high on the next cycle.
REQ-031 SHALL cover: reset asserted at iteration 10 -> next cycle busy = 0, all outputs 0, no done pulse; a subsequent division with in1 = 9, in2 = 3 gives quotient = 3, remainder = 0.
REQ-032 SHALL cover, with DIVIDER_SIGNED_EN and is_signed = 1: -7 / 2 -> quotient = -3, remainder = -1; 32'h80000000 / -1 -> quotient = 32'h80000000, remainder = 0.
REQ-033 SHALL cover, without DIVIDER_SIGNED_EN: is_signed = 1, in1 = 32'hFFFFFFF9, in2 = 2 -> quotient = 32'h7FFFFFFC, remainder = 1.
